// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: writeback control bit positions, default widths
// and the MEM/WB payload layout.
package pipe_pkg;

    localparam int WB_REGWRITE_BIT = 0;
    localparam int WB_MEMTOREG_BIT = 1;

    localparam int DATA_W_D     = 32;
    localparam int REG_ADDR_W_D = 5;
    localparam int CTRL_W_D     = 2;

    // Payload layout at the default widths; field order matches the flat
    // vector packed by mem_wb_stage: {ctrl, alu, rdata, dest}.
    typedef struct packed {
        logic [CTRL_W_D-1:0]     ctrl;
        logic [DATA_W_D-1:0]     alu;
        logic [DATA_W_D-1:0]     rdata;
        logic [REG_ADDR_W_D-1:0] dest;
    } wb_payload_t;

endpackage : pipe_pkg

// File: rtl/mem_wb_stage_if.sv
// MEM/WB boundary bus: upstream valid/ready payload plus the held writeback view.
// master = the surrounding pipeline, slave = the mem_wb_stage itself.
interface mem_wb_stage_if
    import pipe_pkg::*;
#(
    parameter int DATA_W     = DATA_W_D,
    parameter int REG_ADDR_W = REG_ADDR_W_D,
    parameter int CTRL_W     = CTRL_W_D
);

    logic                  in_valid;
    logic                  in_ready;
    logic [CTRL_W-1:0]     in_ctrl;
    logic [DATA_W-1:0]     in_alu;
    logic [DATA_W-1:0]     in_rdata;
    logic [REG_ADDR_W-1:0] in_dest;

    logic                  out_valid;
    logic                  out_ready;
    logic [CTRL_W-1:0]     out_ctrl;
    logic [DATA_W-1:0]     out_alu;
    logic [DATA_W-1:0]     out_rdata;
    logic [REG_ADDR_W-1:0] out_dest;
    logic [DATA_W-1:0]     out_wb_data;
    logic                  out_reg_write;

    modport master (
        output in_valid, in_ctrl, in_alu, in_rdata, in_dest, out_ready,
        input  in_ready, out_valid, out_ctrl, out_alu, out_rdata, out_dest,
               out_wb_data, out_reg_write
    );

    modport slave (
        input  in_valid, in_ctrl, in_alu, in_rdata, in_dest, out_ready,
        output in_ready, out_valid, out_ctrl, out_alu, out_rdata, out_dest,
               out_wb_data, out_reg_write
    );

endinterface : mem_wb_stage_if

// File: rtl/pipe_skid_buf.sv
// Generic 2-entry (main + skid) valid/ready buffer with synchronous flush.
// in_ready comes straight from a flop, so it never depends on out_ready.
module pipe_skid_buf #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,

    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,

    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    logic         main_valid;
    logic         skid_valid;
    logic [W-1:0] main_q;
    logic [W-1:0] skid_q;
    logic         accept;
    logic         pop;

    assign in_ready  = !skid_valid;
    assign accept    = in_valid & in_ready;
    assign pop       = main_valid & out_ready;
    assign out_valid = main_valid;
    assign out_data  = main_q;

    // NOTE: state flops use non-blocking assignments so every register in this
    // block sees the pre-edge values of its neighbours (main <- skid relies on it).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
            // NOTE: payload is reset too, so out_wb_data reads 0 straight out of
            // reset; with only two entries the extra reset fan-out is trivial.
            main_q     <= '0;
            skid_q     <= '0;
        end else if (flush) begin
            // Payload holds; only the valid bits are squashed.
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
        end else if (!main_valid || pop) begin
            if (skid_valid) begin
                main_q     <= skid_q;
                main_valid <= 1'b1;
                skid_valid <= accept;
                if (accept) begin
                    skid_q <= in_data;
                end
            end else begin
                main_valid <= accept;
                if (accept) begin
                    main_q <= in_data;
                end
            end
        end else if (accept) begin
            skid_q     <= in_data;
            skid_valid <= 1'b1;
        end
    end

endmodule : pipe_skid_buf

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline boundary: skid-buffered payload plus writeback mux and
// register-write enable. Define MEMWB_TRACE_EN for a simulation pop/flush trace.
module mem_wb_stage
    import pipe_pkg::*;
#(
    parameter int DATA_W     = DATA_W_D,
    parameter int REG_ADDR_W = REG_ADDR_W_D,
    parameter int CTRL_W     = CTRL_W_D
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           flush,
    mem_wb_stage_if.slave  bus
);

    localparam int PAYLOAD_W = CTRL_W + 2 * DATA_W + REG_ADDR_W;

    generate
        if (CTRL_W < 2) begin : g_ctrl_w_check
            $error("mem_wb_stage: CTRL_W must be at least 2");
        end
    endgenerate

    logic [PAYLOAD_W-1:0] in_payload;
    logic [PAYLOAD_W-1:0] out_payload;

    assign in_payload = {bus.in_ctrl, bus.in_alu, bus.in_rdata, bus.in_dest};

    pipe_skid_buf #(
        .W (PAYLOAD_W)
    ) u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (bus.in_valid),
        .in_ready  (bus.in_ready),
        .in_data   (in_payload),
        .out_valid (bus.out_valid),
        .out_ready (bus.out_ready),
        .out_data  (out_payload)
    );

    assign {bus.out_ctrl, bus.out_alu, bus.out_rdata, bus.out_dest} = out_payload;

    assign bus.out_wb_data = bus.out_ctrl[WB_MEMTOREG_BIT] ? bus.out_rdata : bus.out_alu;

    // x0 is hardwired to zero, so a write targeting it is suppressed here.
    assign bus.out_reg_write = bus.out_valid
                             & bus.out_ctrl[WB_REGWRITE_BIT]
                             & (bus.out_dest != '0);

`ifdef MEMWB_TRACE_EN
    always @(posedge clk) begin
        if (rst_n) begin
            if (flush && (bus.out_valid || !bus.in_ready)) begin
                $display("%0t MEMWB flush", $time);
            end
            if (bus.out_valid && bus.out_ready) begin
                $display("%0t MEMWB pop ctrl=%b dest=%0d alu=%h rdata=%h wb=%h",
                         $time, bus.out_ctrl, bus.out_dest, bus.out_alu,
                         bus.out_rdata, bus.out_wb_data);
            end
        end
    end
`endif

endmodule : mem_wb_stage

// File: tb/tb_mem_wb_stage.sv
// Directed self-checking bench for mem_wb_stage: reset, streaming, backpressure,
// flush, x0 guard and asynchronous reset during a stall.
module tb_mem_wb_stage;

    localparam int DATA_W     = 32;
    localparam int REG_ADDR_W = 5;
    localparam int CTRL_W     = 2;

    logic clk;
    logic rst_n;
    logic flush;

    int checks;
    int failures;

    mem_wb_stage_if #(
        .DATA_W     (DATA_W),
        .REG_ADDR_W (REG_ADDR_W),
        .CTRL_W     (CTRL_W)
    ) bus ();

    mem_wb_stage #(
        .DATA_W     (DATA_W),
        .REG_ADDR_W (REG_ADDR_W),
        .CTRL_W     (CTRL_W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one edge; outputs are read and inputs changed 1ns after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [1:0] ctrl, input logic [31:0] alu,
                         input logic [31:0] rdata, input logic [4:0] dest);
        bus.in_valid = v;
        bus.in_ctrl  = ctrl;
        bus.in_alu   = alu;
        bus.in_rdata = rdata;
        bus.in_dest  = dest;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        flush    = 1'b0;
        bus.out_ready = 1'b0;

        // Reset with random activity on the inputs.
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 2'($urandom), $urandom, $urandom, 5'($urandom));
            bus.out_ready = 1'($urandom);
            step();
        end
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_in_ready", bus.in_ready, 1);
        check("rst_wb_data", bus.out_wb_data, 0);
        check("rst_reg_write", bus.out_reg_write, 0);

        drive(1'b0, 2'b00, 32'h0, 32'h0, 5'd0);
        bus.out_ready = 1'b0;
        rst_n = 1'b1;
        step();
        step();
        check("idle_out_valid", bus.out_valid, 0);
        check("idle_in_ready", bus.in_ready, 1);
        check("idle_wb_data", bus.out_wb_data, 0);

        // Streaming: one entry per clock, each visible one edge after accept.
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 2'b01, 32'h10 + 32'(i), 32'hF0 + 32'(i), 5'd3);
            step();
            check($sformatf("stream%0d_valid", i), bus.out_valid, 1);
            check($sformatf("stream%0d_wb", i), bus.out_wb_data, 64'h10 + 64'(i));
            check($sformatf("stream%0d_we", i), bus.out_reg_write, 1);
            check($sformatf("stream%0d_in_ready", i), bus.in_ready, 1);
        end
        drive(1'b0, 2'b00, 32'h0, 32'h0, 5'd0);
        step();
        check("stream_drain_valid", bus.out_valid, 0);

        // Backpressure: A into main, B into skid, then a blocked third entry.
        bus.out_ready = 1'b0;
        drive(1'b1, 2'b11, 32'h1A, 32'hAA, 5'd5);
        step();
        check("bp_a_valid", bus.out_valid, 1);
        check("bp_a_in_ready", bus.in_ready, 1);
        drive(1'b1, 2'b01, 32'hB0, 32'hBB, 5'd6);
        step();
        check("bp_full_in_ready", bus.in_ready, 0);
        check("bp_a_wb", bus.out_wb_data, 64'hAA);
        drive(1'b1, 2'b01, 32'hDD, 32'hDD, 5'd9);
        step();
        step();
        check("bp_stall_valid", bus.out_valid, 1);
        check("bp_stall_dest", bus.out_dest, 5);
        check("bp_stall_wb", bus.out_wb_data, 64'hAA);
        check("bp_stall_in_ready", bus.in_ready, 0);
        drive(1'b0, 2'b00, 32'h0, 32'h0, 5'd0);
        bus.out_ready = 1'b1;
        step();
        check("bp_b_valid", bus.out_valid, 1);
        check("bp_b_alu", bus.out_alu, 64'hB0);
        check("bp_b_wb", bus.out_wb_data, 64'hB0);
        check("bp_b_in_ready", bus.in_ready, 1);
        step();
        check("bp_empty_valid", bus.out_valid, 0);

        // Flush with both entries held and C offered on the same edge.
        bus.out_ready = 1'b0;
        drive(1'b1, 2'b01, 32'hE0, 32'hE1, 5'd7);
        step();
        drive(1'b1, 2'b01, 32'hF0, 32'hF1, 5'd8);
        step();
        check("fl_full_in_ready", bus.in_ready, 0);
        drive(1'b1, 2'b01, 32'hCC, 32'hCC, 5'd10);
        flush = 1'b1;
        step();
        flush = 1'b0;
        drive(1'b0, 2'b00, 32'h0, 32'h0, 5'd0);
        check("fl_out_valid", bus.out_valid, 0);
        check("fl_in_ready", bus.in_ready, 1);
        check("fl_reg_write", bus.out_reg_write, 0);
        check("fl_payload_hold", bus.out_alu, 64'hE0);
        bus.out_ready = 1'b1;
        step();
        step();
        check("fl_no_c_valid", bus.out_valid, 0);

        // Flush with only main held: the accepted entry H is dropped.
        bus.out_ready = 1'b0;
        drive(1'b1, 2'b01, 32'h60, 32'h61, 5'd4);
        step();
        drive(1'b1, 2'b01, 32'h70, 32'h71, 5'd4);
        flush = 1'b1;
        step();
        flush = 1'b0;
        drive(1'b0, 2'b00, 32'h0, 32'h0, 5'd0);
        step();
        check("fl1_out_valid", bus.out_valid, 0);
        check("fl1_in_ready", bus.in_ready, 1);

        // Register-zero guard.
        bus.out_ready = 1'b1;
        drive(1'b1, 2'b01, 32'h55, 32'h66, 5'd0);
        step();
        check("x0_valid", bus.out_valid, 1);
        check("x0_reg_write", bus.out_reg_write, 0);
        check("x0_wb", bus.out_wb_data, 64'h55);
        drive(1'b0, 2'b00, 32'h0, 32'h0, 5'd0);
        step();
        check("x0_after_valid", bus.out_valid, 0);
        check("x0_after_wb_hold", bus.out_wb_data, 64'h55);

        // Asynchronous reset between edges while two entries are held.
        bus.out_ready = 1'b0;
        drive(1'b1, 2'b01, 32'h81, 32'h82, 5'd11);
        step();
        drive(1'b1, 2'b01, 32'h91, 32'h92, 5'd12);
        step();
        drive(1'b0, 2'b00, 32'h0, 32'h0, 5'd0);
        check("ar_pre_valid", bus.out_valid, 1);
        check("ar_pre_in_ready", bus.in_ready, 0);
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_out_valid", bus.out_valid, 0);
        check("ar_in_ready", bus.in_ready, 1);
        check("ar_wb_data", bus.out_wb_data, 0);
        check("ar_reg_write", bus.out_reg_write, 0);
        step();
        rst_n = 1'b1;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_mem_wb_stage

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
- Parametrised MEM/WB pipeline boundary register with a valid/ready handshake and a 2-entry skid buffer (main + skid).
- Also supports flush, and generates the writeback mux result and register-write enable.
- Sits between the data-memory stage and the register-file write port.
- Replaces the unconditional per-clock latch with stall-tolerant, bubble-aware transfer.

Parameters:
- DATA_W, 32, width of the ALU result, read data and writeback data.
- REG_ADDR_W, 5, width of the destination register index.
- CTRL_W, 2, width of the WB control field (minimum 2): bit0 = RegWrite, bit1 = MemtoReg; upper bits are passed through.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  synchronous squash of all held entries
- in_valid  in  1  upstream entry present
- in_ready  out  1  stage can accept an entry
- in_ctrl  in  CTRL_W  WB control
- in_alu  in  DATA_W  ALU result
- in_rdata  in  DATA_W  memory read data
- in_dest  in  REG_ADDR_W  destination register
- out_valid  out  1  main entry valid
- out_ready  in  1  writeback consumes the entry
- out_ctrl  out  CTRL_W  held WB control
- out_alu  out  DATA_W  held ALU result
- out_rdata  out  DATA_W  held read data
- out_dest  out  REG_ADDR_W  held destination
- out_wb_data  out  DATA_W  out_ctrl[1] ? out_rdata : out_alu
- out_reg_write  out  1  out_valid & out_ctrl[0] & (out_dest != 0)

Behaviour:
- Clocking and reset: one clock, clk; reset rst_n is asynchronous, active-low.
- Reset: main_valid = 0, skid_valid = 0, and all payload registers = 0.
  - Consequences: out_valid = 0, out_wb_data = 0, out_reg_write = 0, in_ready = 1.
  - Reset asserted mid-transfer discards everything immediately.
- in_ready is registered-derived: in_ready = !skid_valid. It does not depend combinationally on out_ready.
- Handshake events:
  - accept = in_valid & in_ready
  - pop = out_valid & out_ready
  - Payload on in_* is sampled only on accept.
- Latency: an accepted entry appears on out_* the cycle after acceptance when main is empty or popping (1 cycle).
- Per-edge update, evaluated in priority order:
  1. flush=1: main_valid <- 0 and skid_valid <- 0. A same-cycle accept is dropped and a same-cycle pop still counts as consumed. Payload registers hold.
  2. Main empty or pop:
     - If skid_valid, main <- skid and skid_valid <- accept (skid <- input if accept).
     - Else main <- input, main_valid <- accept.
  3. Main full and no pop:
     - If accept, skid <- input and skid_valid <- 1.
     - Main holds.
- Full condition: skid_valid = 1 drives in_ready = 0. No accept is possible, so there is no overflow.
- Ordering: strict FIFO order, at most 2 entries in flight.
- Stall: out_ready = 0 for N cycles holds out_* stable and keeps out_valid high.
- Throughput: 1 entry per clock when out_ready stays high.
- Payload registers hold their last value while invalid.
  - out_wb_data may therefore be nonzero with out_valid = 0.
  - out_reg_write is always gated by out_valid.
- Register 0 is never written: dest = 0 forces out_reg_write = 0.

Optional Feature:
- Macro: MEMWB_TRACE_EN.
- Defined: on every pop, a simulation-only $display prints time, out_ctrl, out_dest, out_alu, out_rdata and out_wb_data in binary/hex. On flush with a nonzero entry count, it prints "MEMWB flush".
- Undefined: no display code is compiled and the netlist is identical.

Decomposition:
- Shared package pipe_pkg holds:
  - WB_REGWRITE_BIT = 0 and WB_MEMTOREG_BIT = 1
  - default widths DATA_W_D = 32 and REG_ADDR_W_D = 5
  - a packed struct typedef wb_payload_t {ctrl, alu, rdata, dest}
- Sub-module: pipe_skid_buf, a generic payload-width 2-entry valid/ready skid buffer with flush.
- mem_wb_stage instantiates pipe_skid_buf and adds the writeback mux and write-enable logic.

Test Plan:
- Reset: hold rst_n = 0 with random inputs -> out_valid = 0, in_ready = 1, out_wb_data = 0. Deassert, drive nothing -> outputs unchanged.
- Streaming: out_ready = 1, 4 back-to-back entries with alu = 0x10..0x13, ctrl = 2'b01, dest = 3 -> each appears 1 cycle later, out_wb_data = alu, out_reg_write = 1, no bubbles.
- Backpressure: out_ready = 0, push A (rdata = 0xAA, ctrl = 2'b11) then B -> in_ready = 0 after B, out_* = A held. Raise out_ready -> A popped, then B, in order. in_ready returns to 1 one cycle after the skid drains.
- Flush with full buffer: 2 entries held, flush = 1 with in_valid = 1 (C) -> next cycle out_valid = 0, in_ready = 1, C never appears.
- Register-zero guard: entry with dest = 0, ctrl = 2'b01, alu = 0x55 -> out_valid = 1, out_reg_write = 0, out_wb_data = 0x55.
- Async reset mid-stall: 2 entries held, rst_n pulsed low between clock edges -> out_valid drops without a clock edge, in_ready = 1.
